mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction cache (read-only, one-word fills) and the data cache (two-word block fills and write-backs).
- Grants the port to one requester at a time and holds a data-cache grant for the whole block burst, so that block words are never interleaved with instruction fetches.
- Data cache has priority; a fairness flag prevents instruction-cache starvation.
- Sits between both caches and the RAM/bus model.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every non-clock signal around the RAM port arbiter.
//   icache side : iREN, iaddr -> arbiter ; iwait, iload <- arbiter
//   dcache side : dREN, dWEN, daddr, dstore -> arbiter ; dwait, dload <- arbiter
//   RAM side    : ramREN, ramWEN, ramaddr, ramstore <- arbiter ; ramload, ramstate -> arbiter
//   status      : err_timeout (watchdog pulse), dbg_state, dbg_wcnt (FSM visibility)
// Modports: slave = the arbiter itself, master = the environment (caches + RAM model).
//
// Handshake: a requester holds its enable(s) and address/data stable while its
// wait output is 1; a word is transferred in exactly the cycle where the wait
// output is 0 (the granted requester's enable is high and ramstate == ACCESS),
// and the matching load output is only meaningful in that cycle.
// dbg_state encoding: 0 = IDLE, 1 = IGRANT, 2 = DGRANT.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err_timeout;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_wcnt;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           err_timeout, dbg_state, dbg_wcnt
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           err_timeout, dbg_state, dbg_wcnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction cache (single-word
// reads) and the data cache (BURST_LEN-word block reads/writes). The data cache
// has priority, but after a completed data burst with the icache waiting, the
// icache goes first (ifirst). A data grant is held for the whole burst.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave: cache requests/stalls/loads, RAM control,
//          err_timeout watchdog pulse and FSM debug state/word count.
// Parameters: BURST_LEN (1..8) words per data grant; MAX_WAIT stall cycles
// tolerated per word before err_timeout pulses.
module mem_arbiter #(
  parameter int BURST_LEN = 2,
  parameter int MAX_WAIT  = 255
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);
  localparam int WCNT_W = $clog2(BURST_LEN + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [1:0]        RAM_ACCESS = 2'b10;
  localparam logic [WCNT_W-1:0] BURST_LAST = WCNT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                ifirst_q, ifirst_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic                access;

  assign access = (bus.ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      ifirst_q <= 1'b0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ifirst_q <= ifirst_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    ifirst_d     = ifirst_q;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      IDLE: begin
        if ((bus.dREN || bus.dWEN) && (!ifirst_q || !bus.iREN)) state_d = DGRANT;
        else if (bus.iREN)                                      state_d = IGRANT;
      end
      IGRANT: begin
        bus.iload = bus.ramload;
        if (bus.iREN) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (access) begin
            bus.iwait = 1'b0;
            state_d   = IDLE;
            ifirst_d  = 1'b0;
          end
        end else begin
          // Requester withdrew: release the port without completing a word.
          state_d = IDLE;
        end
      end
      DGRANT: begin
        bus.dload = bus.ramload;
        if (bus.dWEN) begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
        end else if (bus.dREN) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.daddr;
        end
        if (bus.dREN || bus.dWEN) begin
          if (access) begin
            bus.dwait = 1'b0;
            // Last word of the block: hand the next slot to a waiting icache.
            if (wcnt_q == BURST_LAST) begin
              state_d  = IDLE;
              wcnt_d   = '0;
              ifirst_d = bus.iREN;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end else begin
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Watchdog: counts stalled granted cycles; the pulse is registered so it
  // lands in the cycle after the count reaches MAX_WAIT. The grant is kept.
  always_comb begin
    wait_d = wait_q;
    err_d  = 1'b0;
    if (state_q == IDLE || access) begin
      wait_d = '0;
    end else if ((wait_q + 1'b1) == WAIT_LIMIT) begin
      wait_d = '0;
      err_d  = 1'b1;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
  assign bus.dbg_state   = state_q;
  assign bus.dbg_wcnt    = 4'(wcnt_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written reset/early-release
// sequence, then randomized traffic checked against a grant-level reference
// model. Runs with BURST_LEN = 2 and MAX_WAIT = 4.
module tb_mem_arbiter;
  localparam int BURST   = 2;
  localparam int MAXW    = 4;
  localparam logic [1:0] RS_F = 2'b00, RS_B = 2'b01, RS_A = 2'b10, RS_E = 2'b11;
  localparam logic [1:0] S_I = 2'd0, S_IG = 2'd1, S_DG = 2'd2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_arbiter_if bus();

  mem_arbiter #(.BURST_LEN(BURST), .MAX_WAIT(MAXW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL time_limit: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- driver / checker ----------------
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] ds, input logic [31:0] rl,
                       input logic [1:0] rs);
    @(negedge clk);
    rst          = r;
    bus.iREN     = ir;
    bus.iaddr    = ia;
    bus.dREN     = dr;
    bus.dWEN     = dw;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramload  = rl;
    bus.ramstate = rs;
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst, iren;
    logic [31:0] iaddr;
    logic        dren, dwen;
    logic [31:0] daddr, dstore, ramload;
    logic [1:0]  rs;
    logic        e_iwait, e_dwait;
    logic [31:0] e_iload, e_dload;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_err;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[18];

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, "_iwait"},  bus.iwait,       v.e_iwait);
    chk({tag, "_dwait"},  bus.dwait,       v.e_dwait);
    chk({tag, "_iload"},  bus.iload,       v.e_iload);
    chk({tag, "_dload"},  bus.dload,       v.e_dload);
    chk({tag, "_ramREN"}, bus.ramREN,      v.e_ren);
    chk({tag, "_ramWEN"}, bus.ramWEN,      v.e_wen);
    chk({tag, "_ramaddr"},bus.ramaddr,     v.e_addr);
    chk({tag, "_ramstore"},bus.ramstore,   v.e_store);
    chk({tag, "_err"},    bus.err_timeout, v.e_err);
    chk({tag, "_state"},  bus.dbg_state,   v.e_state);
  endtask

  // ---------------- reference model ----------------
  // grant: 0 none, 1 icache, 2 dcache; left = words still owed in the burst.
  int  m_grant, m_left, m_stall;
  bit  m_ifirst, m_err;
  logic cur_ir, cur_dr, cur_dw;

  task automatic run_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic        r;
      logic [31:0] ia, da, ds, rl;
      logic [1:0]  rs;
      int          pick, n_grant, n_left, n_stall;
      bit          n_ifirst, n_err, acc;
      logic        e_iwait, e_dwait, e_ren, e_wen;
      logic [31:0] e_iload, e_dload, e_addr, e_store;
      string       tag;

      if ($urandom_range(0, 3) == 0) cur_ir = ~cur_ir;
      if ($urandom_range(0, 3) == 0) cur_dr = ~cur_dr;
      if ($urandom_range(0, 4) == 0) cur_dw = ~cur_dw;
      r    = ($urandom_range(0, 199) == 0);
      ia   = $urandom;
      da   = $urandom;
      ds   = $urandom;
      rl   = $urandom;
      pick = $urandom_range(0, 5);
      rs   = (pick == 0) ? RS_F : (pick == 1) ? RS_B : (pick == 2) ? RS_E : RS_A;
      drive(r, cur_ir, ia, cur_dr, cur_dw, da, ds, rl, rs);

      acc = (rs == RS_A);
      e_iwait = 1'b1; e_dwait = 1'b1; e_iload = '0; e_dload = '0;
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      n_grant = m_grant; n_left = m_left; n_ifirst = m_ifirst;

      if (m_grant == 0) begin
        if ((cur_dr || cur_dw) && (!m_ifirst || !cur_ir)) begin
          n_grant = 2; n_left = BURST;
        end else if (cur_ir) begin
          n_grant = 1;
        end
      end else if (m_grant == 1) begin
        e_iload = rl;
        if (!cur_ir) n_grant = 0;
        else begin
          e_ren = 1'b1; e_addr = ia;
          if (acc) begin e_iwait = 1'b0; n_grant = 0; n_ifirst = 1'b0; end
        end
      end else begin
        e_dload = rl;
        if (!(cur_dr || cur_dw)) begin
          n_grant = 0;
        end else begin
          if (cur_dw) begin e_wen = 1'b1; e_addr = da; e_store = ds; end
          else        begin e_ren = 1'b1; e_addr = da; end
          if (acc) begin
            e_dwait = 1'b0;
            n_left  = m_left - 1;
            if (n_left == 0) begin n_grant = 0; n_ifirst = cur_ir; end
          end
        end
      end

      n_err = 1'b0;
      if (m_grant == 0 || acc) n_stall = 0;
      else begin
        n_stall = m_stall + 1;
        if (n_stall == MAXW) begin n_err = 1'b1; n_stall = 0; end
      end

      tag = $sformatf("rnd%0d", c);
      chk({tag, "_iwait"},   bus.iwait,       e_iwait);
      chk({tag, "_dwait"},   bus.dwait,       e_dwait);
      chk({tag, "_iload"},   bus.iload,       e_iload);
      chk({tag, "_dload"},   bus.dload,       e_dload);
      chk({tag, "_ramREN"},  bus.ramREN,      e_ren);
      chk({tag, "_ramWEN"},  bus.ramWEN,      e_wen);
      chk({tag, "_ramaddr"}, bus.ramaddr,     e_addr);
      chk({tag, "_ramstore"},bus.ramstore,    e_store);
      chk({tag, "_err"},     bus.err_timeout, m_err);
      chk({tag, "_state"},   bus.dbg_state,   m_grant[1:0]);

      if (r) begin
        m_grant = 0; m_left = 0; m_ifirst = 1'b0; m_stall = 0; m_err = 1'b0;
      end else begin
        m_grant = n_grant; m_left = n_left; m_ifirst = n_ifirst;
        m_stall = n_stall; m_err = n_err;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = RS_F;

    //            rst iren iaddr dren dwen daddr  dstore        ramload       rs  | iw dw iload         dload  ren wen addr   store         err state
    vecs[0]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};
    vecs[1]  = '{0, 1, 32'h40, 0, 0, 32'h0,   32'h0,        32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};
    vecs[2]  = '{0, 1, 32'h40, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF, RS_A, 0, 1, 32'hDEADBEEF, 32'h0,  1, 0, 32'h40,  32'h0,        0, S_IG};
    vecs[3]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};
    vecs[4]  = '{0, 1, 32'h80, 1, 0, 32'h100, 32'h0,        32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};
    vecs[5]  = '{0, 1, 32'h80, 1, 0, 32'h100, 32'h0,        32'h11,       RS_A, 1, 0, 32'h0,        32'h11, 1, 0, 32'h100, 32'h0,        0, S_DG};
    vecs[6]  = '{0, 1, 32'h80, 1, 0, 32'h104, 32'h0,        32'h22,       RS_A, 1, 0, 32'h0,        32'h22, 1, 0, 32'h104, 32'h0,        0, S_DG};
    vecs[7]  = '{0, 1, 32'h80, 1, 0, 32'h108, 32'h0,        32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};
    vecs[8]  = '{0, 1, 32'h80, 1, 0, 32'h108, 32'h0,        32'h33,       RS_A, 0, 1, 32'h33,       32'h0,  1, 0, 32'h80,  32'h0,        0, S_IG};
    vecs[9]  = '{0, 0, 32'h0,  1, 1, 32'h200, 32'hCAFE0000, 32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};
    vecs[10] = '{0, 0, 32'h0,  1, 1, 32'h200, 32'hCAFE0000, 32'h55,       RS_A, 1, 0, 32'h0,        32'h55, 0, 1, 32'h200, 32'hCAFE0000, 0, S_DG};
    vecs[11] = '{0, 0, 32'h0,  0, 1, 32'h204, 32'h1234,     32'h0,        RS_B, 1, 1, 32'h0,        32'h0,  0, 1, 32'h204, 32'h1234,     0, S_DG};
    vecs[12] = '{0, 0, 32'h0,  0, 1, 32'h204, 32'h1234,     32'h0,        RS_B, 1, 1, 32'h0,        32'h0,  0, 1, 32'h204, 32'h1234,     0, S_DG};
    vecs[13] = '{0, 0, 32'h0,  0, 1, 32'h204, 32'h1234,     32'h0,        RS_B, 1, 1, 32'h0,        32'h0,  0, 1, 32'h204, 32'h1234,     0, S_DG};
    vecs[14] = '{0, 0, 32'h0,  0, 1, 32'h204, 32'h1234,     32'h0,        RS_E, 1, 1, 32'h0,        32'h0,  0, 1, 32'h204, 32'h1234,     0, S_DG};
    vecs[15] = '{0, 0, 32'h0,  0, 1, 32'h204, 32'h1234,     32'h0,        RS_E, 1, 1, 32'h0,        32'h0,  0, 1, 32'h204, 32'h1234,     1, S_DG};
    vecs[16] = '{0, 0, 32'h0,  0, 1, 32'h204, 32'h1234,     32'h77,       RS_A, 1, 0, 32'h0,        32'h77, 0, 1, 32'h204, 32'h1234,     0, S_DG};
    vecs[17] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        32'h0,        RS_F, 1, 1, 32'h0,        32'h0,  0, 0, 32'h0,   32'h0,        0, S_I};

    drive(1, 0, 0, 0, 0, 0, 0, 0, RS_F);
    drive(1, 0, 0, 0, 0, 0, 0, 0, RS_F);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
            vecs[i].daddr, vecs[i].dstore, vecs[i].ramload, vecs[i].rs);
      check_vec($sformatf("v%0d", i), vecs[i]);
    end
    chk("v17_wcnt", bus.dbg_wcnt, 4'd0);

    // Reset after the first word of a fill, then restart and release early.
    drive(0, 0, 0, 1, 0, 32'h300, 0, 0,     RS_F);
    drive(0, 0, 0, 1, 0, 32'h300, 0, 32'h9, RS_A);
    chk("rst_word1_dwait", bus.dwait,     1'b0);
    chk("rst_word1_dload", bus.dload,     32'h9);
    drive(1, 0, 0, 1, 0, 32'h304, 0, 0,     RS_F);
    chk("rst_cycle_wcnt",  bus.dbg_wcnt,  4'd1);
    drive(0, 0, 0, 1, 0, 32'h304, 0, 0,     RS_F);
    chk("after_rst_state", bus.dbg_state, S_I);
    chk("after_rst_wcnt",  bus.dbg_wcnt,  4'd0);
    chk("after_rst_ren",   bus.ramREN,    1'b0);
    chk("after_rst_wen",   bus.ramWEN,    1'b0);
    chk("after_rst_dwait", bus.dwait,     1'b1);
    drive(0, 0, 0, 1, 0, 32'h300, 0, 32'hA, RS_A);
    chk("restart_state",   bus.dbg_state, S_DG);
    chk("restart_wcnt",    bus.dbg_wcnt,  4'd0);
    chk("restart_dwait",   bus.dwait,     1'b0);
    drive(0, 0, 0, 1, 0, 32'h304, 0, 0,     RS_B);
    chk("restart_w2_state",bus.dbg_state, S_DG);
    chk("restart_w2_wcnt", bus.dbg_wcnt,  4'd1);
    chk("restart_w2_dwait",bus.dwait,     1'b1);
    drive(0, 0, 0, 0, 0, 32'h304, 0, 0,     RS_B);
    chk("release_state",   bus.dbg_state, S_DG);
    chk("release_ren",     bus.ramREN,    1'b0);
    chk("release_wen",     bus.ramWEN,    1'b0);
    chk("release_dwait",   bus.dwait,     1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0,           RS_F);
    chk("released_state",  bus.dbg_state, S_I);
    chk("released_wcnt",   bus.dbg_wcnt,  4'd0);

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 0, RS_F);
    m_grant = 0; m_left = 0; m_ifirst = 1'b0; m_stall = 0; m_err = 1'b0;
    cur_ir = 1'b0; cur_dr = 1'b0; cur_dw = 1'b0;
    run_random(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
